// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-type constants, used by uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the UART receiver's serial input, frame configuration and parallel result strobes.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);

  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stop_err;

  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stop_err
  );

  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stop_err
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and bit-value decision for uart_rx.
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around the sample point instead of a single sample.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_val,
  output logic                  decide,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] sp;

  assign sp       = prescale >> 1;
  assign bit_done = (edge_cnt == PRESCALE_W'(prescale - 1'b1));
  assign decide   = (edge_cnt == PRESCALE_W'(sp + 1'b1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      edge_cnt <= '0;
    else if (clear || bit_done)
      edge_cnt <= '0;
    else
      edge_cnt <= edge_cnt + 1'b1;
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic samp_early;
  logic samp_mid;

  // The third vote is the live synced bit during the decision cycle (SP+1).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_early <= 1'b1;
      samp_mid   <= 1'b1;
    end else begin
      if (edge_cnt == PRESCALE_W'(sp - 1'b1))
        samp_early <= rx_s;
      if (edge_cnt == sp)
        samp_mid <= rx_s;
    end
  end

  assign bit_val = (samp_early & samp_mid) | (samp_early & rx_s) | (samp_mid & rx_s);
`else
  logic samp_mid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      samp_mid <= 1'b1;
    else if (edge_cnt == sp)
      samp_mid <= rx_s;
  end

  assign bit_val = samp_mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, deframes start/data/parity/stop and strobes the result.
// Optional build macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 bit voting in the sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  uart_state_e           state, next_state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_flag;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stop_err_q;
  logic                  bit_val;
  logic                  decide;
  logic                  bit_done;
  logic                  frame_start;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      sync <= 2'b11;
    else
      sync <= {sync[0], bus.rx_in};
  end

  assign rx_s = sync[1];

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (state == IDLE),
    .rx_s     (rx_s),
    .prescale (prescale_q),
    .bit_val  (bit_val),
    .decide   (decide),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state <= IDLE;
    else
      state <= next_state;
  end

  // STOP returns to IDLE at its decision cycle so a back-to-back start edge is not missed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START: begin
        if (decide && bit_val)
          next_state = IDLE;
        else if (bit_done)
          next_state = DATA;
      end
      DATA:    if (bit_done && bit_cnt == CNT_W'(DATA_WIDTH - 1))
                 next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (decide) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign frame_start = (state == IDLE) && (next_state == START);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      prescale_q   <= PRESCALE_W'(8);
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_flag     <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      if (frame_start) begin
        par_en_q   <= bus.par_en;
        par_typ_q  <= bus.par_typ;
        prescale_q <= bus.prescale;
        bit_cnt    <= '0;
        par_flag   <= 1'b0;
      end
      case (state)
        DATA: begin
          if (decide)
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
          if (bit_done)
            bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: begin
          if (decide)
            par_flag <= (bit_val != (^shift_reg ^ par_typ_q));
        end
        STOP: begin
          if (decide) begin
            stop_err_q <= ~bit_val;
            par_err_q  <= par_flag;
            if (bit_val && !par_flag) begin
              p_data_q     <= shift_reg;
              data_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames with and without parity, errors, reset abort, Prescale=16 traffic.
module tb_uart_rx;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   dv_cnt, pe_cnt, se_cnt, dbl_cnt;
  int   dv_base, pe_base, se_base;
  logic dv_prev;
  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];

  uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse recorder: counts strobes and flags any strobe lasting longer than one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_valid) begin
        dv_cnt = dv_cnt + 1;
        rx_q.push_back(bus.p_data);
        if (dv_prev) dbl_cnt = dbl_cnt + 1;
      end
      if (bus.par_err) pe_cnt = pe_cnt + 1;
      if (bus.stop_err) se_cnt = se_cnt + 1;
      dv_prev = bus.data_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveBit(input logic v, input int ticks);
    bus.rx_in = v;
    repeat (ticks) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic has_par, input logic par_bit,
                               input logic stop_bit, input int ticks);
    driveBit(1'b0, ticks);
    for (int i = 0; i < 8; i++) driveBit(d[i], ticks);
    if (has_par) driveBit(par_bit, ticks);
    driveBit(stop_bit, ticks);
  endtask

  task automatic snapshot();
    dv_base = dv_cnt;
    pe_base = pe_cnt;
    se_base = se_cnt;
    rx_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       typ;
    checks  = 0;
    errors  = 0;
    dv_cnt  = 0;
    pe_cnt  = 0;
    se_cnt  = 0;
    dbl_cnt = 0;
    dv_prev = 1'b0;
    rst_n   = 1'b0;
    bus.rx_in    = 1'b1;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    bus.prescale = 6'd8;
    repeat (3) @(negedge clk);
    checkOutput("reset_p_data", 32'(bus.p_data), 32'h0);
    checkOutput("reset_data_valid", 32'(bus.data_valid), 32'h0);
    checkOutput("reset_par_err", 32'(bus.par_err), 32'h0);
    checkOutput("reset_stop_err", 32'(bus.stop_err), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] odd parity frame 0xCB");
    snapshot();
    bus.par_en  = 1'b1;
    bus.par_typ = 1'b1;
    applyStimulus(8'hCB, 1'b1, 1'b0, 1'b1, 8);
    repeat (10) @(negedge clk);
    checkOutput("t1_dv_count", 32'(dv_cnt - dv_base), 32'd1);
    checkOutput("t1_data", 32'(rx_q[0]), 32'hCB);
    checkOutput("t1_p_data_hold", 32'(bus.p_data), 32'hCB);
    checkOutput("t1_par_err", 32'(pe_cnt - pe_base), 32'd0);
    checkOutput("t1_stop_err", 32'(se_cnt - se_base), 32'd0);

    $display("[TB] back-to-back 0x6A, 0x55 without parity");
    snapshot();
    bus.par_en = 1'b0;
    applyStimulus(8'h6A, 1'b0, 1'b0, 1'b1, 8);
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 8);
    repeat (10) @(negedge clk);
    checkOutput("t2_dv_count", 32'(dv_cnt - dv_base), 32'd2);
    checkOutput("t2_first", 32'(rx_q[0]), 32'h6A);
    checkOutput("t2_second", 32'(rx_q[1]), 32'h55);

    $display("[TB] parity error frame");
    snapshot();
    bus.par_en  = 1'b1;
    bus.par_typ = 1'b1;
    applyStimulus(8'hCB, 1'b1, 1'b1, 1'b1, 8);
    repeat (10) @(negedge clk);
    checkOutput("t3_par_err", 32'(pe_cnt - pe_base), 32'd1);
    checkOutput("t3_dv_count", 32'(dv_cnt - dv_base), 32'd0);
    checkOutput("t3_stop_err", 32'(se_cnt - se_base), 32'd0);
    checkOutput("t3_p_data_kept", 32'(bus.p_data), 32'h55);

    $display("[TB] stop error and short glitch");
    snapshot();
    bus.par_en = 1'b0;
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 8);
    driveBit(1'b1, 20);
    checkOutput("t4_stop_err", 32'(se_cnt - se_base), 32'd1);
    checkOutput("t4_stop_dv", 32'(dv_cnt - dv_base), 32'd0);
    checkOutput("t4_stop_par", 32'(pe_cnt - pe_base), 32'd0);
    checkOutput("t4_stop_p_data", 32'(bus.p_data), 32'h55);
    snapshot();
    driveBit(1'b0, 2);
    driveBit(1'b1, 20);
    checkOutput("t4_glitch_pulses", 32'((dv_cnt - dv_base) + (pe_cnt - pe_base) + (se_cnt - se_base)), 32'd0);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 8);
    repeat (10) @(negedge clk);
    checkOutput("t4_recover_dv", 32'(dv_cnt - dv_base), 32'd1);
    checkOutput("t4_recover_data", 32'(rx_q[0]), 32'h81);

    $display("[TB] reset during data bit 3");
    snapshot();
    driveBit(1'b0, 8);
    driveBit(1'b1, 8);
    driveBit(1'b0, 8);
    driveBit(1'b1, 8);
    driveBit(1'b0, 4);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_rst_p_data", 32'(bus.p_data), 32'h0);
    checkOutput("t5_rst_data_valid", 32'(bus.data_valid), 32'h0);
    checkOutput("t5_rst_errs", 32'({bus.par_err, bus.stop_err}), 32'h0);
    bus.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 8);
    repeat (10) @(negedge clk);
    checkOutput("t5_dv_count", 32'(dv_cnt - dv_base), 32'd1);
    checkOutput("t5_data", 32'(rx_q[0]), 32'hA5);
    checkOutput("t5_errs", 32'((pe_cnt - pe_base) + (se_cnt - se_base)), 32'd0);

    $display("[TB] Prescale=16 traffic, both parities");
    snapshot();
    sent_q.delete();
    bus.prescale = 6'd16;
    bus.par_en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b   = 8'($urandom_range(0, 255));
      typ = 1'(i % 2);
      bus.par_typ = typ;
      sent_q.push_back(b);
      applyStimulus(b, 1'b1, (^b) ^ typ, 1'b1, 16);
      driveBit(1'b1, 4);
    end
    repeat (10) @(negedge clk);
    checkOutput("t6_dv_count", 32'(dv_cnt - dv_base), 32'd8);
    checkOutput("t6_errs", 32'((pe_cnt - pe_base) + (se_cnt - se_base)), 32'd0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t6_byte%0d", i), 32'(rx_q[i]), 32'(sent_q[i]));

`ifdef UART_RX_MAJORITY_VOTE_EN
    $display("[TB] single-tick glitch at sample point");
    snapshot();
    bus.par_en = 1'b0;
    driveBit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      b = 8'hF0;
      if (i == 2) begin
        driveBit(b[i], 9);
        driveBit(~b[i], 1);
        driveBit(b[i], 6);
      end else begin
        driveBit(b[i], 16);
      end
    end
    driveBit(1'b1, 26);
    checkOutput("t6_vote_dv", 32'(dv_cnt - dv_base), 32'd1);
    checkOutput("t6_vote_data", 32'(rx_q[0]), 32'hF0);
`endif

    checkOutput("single_cycle_valid", 32'(dbl_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
